instr_fetch_unit: RTL

- Byte-serial instruction fetch stage directly upstream of the multicycle control FSM (statelogic).
- On a fetch request, reads four bytes from an 8-bit instruction memory over a req/ack handshake and assembles a 32-bit instruction word.
- Presents op (instr[31:26]) to statelogic and advances the PC.
- Supports PC redirect for branches and jumps.

---
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: gathers four little-endian bytes over a
// req/ack memory port into a 32-bit word and advances the PC.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc,
  output logic              valid,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [31:0]       instr_reg, instr_next;
  logic [23:0]       shadow_reg, shadow_next;
  logic              valid_reg, valid_next;
  logic              capture;
  logic [7:0]        lane_next [3];

  // Lower three bytes park in the shadow register; the fourth commits directly.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_next[gi] = (capture && (cnt_reg == 2'(gi))) ? mem_data
                                                              : shadow_reg[8*gi +: 8];
    end
  endgenerate

  assign shadow_next = {lane_next[2], lane_next[1], lane_next[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 2'd0;
      pc_reg     <= RESET_PC;
      instr_reg  <= 32'd0;
      shadow_reg <= 24'd0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      shadow_reg <= shadow_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    capture    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // Redirect is applied first so a simultaneous fetch starts at pc_in.
        if (pc_load) begin
          pc_next    = pc_in;
          valid_next = 1'b0;
        end
        if (fetch) begin
          state_next = RD;
          cnt_next   = 2'd0;
          valid_next = 1'b0;
        end
      end
      RD: begin
        if (pc_load) begin
          pc_next    = pc_in;
          state_next = IDLE;
          cnt_next   = 2'd0;
        end else if (mem_ack) begin
          if (cnt_reg == 2'd3) begin
            instr_next = {mem_data, shadow_reg};
            pc_next    = pc_reg + ADDR_W'(4);
            valid_next = 1'b1;
            state_next = IDLE;
            cnt_next   = 2'd0;
          end else begin
            capture  = 1'b1;
            cnt_next = cnt_reg + 2'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg == RD);
  assign mem_rd   = busy;
  assign mem_addr = busy ? ADDR_W'(pc_reg + ADDR_W'(cnt_reg)) : '0;
  assign instr    = instr_reg;
  assign op       = instr_reg[31:26];
  assign funct    = instr_reg[5:0];
  assign pc       = pc_reg;
  assign valid    = valid_reg;

endmodule
